// File: rtl/bus_ctrl_pkg.sv
// bus_ctrl_pkg
// Shared constants and types for the data-side bus controller:
//   - word-aligned addresses of the memory-mapped peripheral registers
//   - data RAM region limit and a helper that checks it
//   - bit positions inside the UART status word
//   - encoding of the UART transmitter state machine
package bus_ctrl_pkg;

   localparam logic [31:0] ADDR_LED       = 32'h0000_F000;
   localparam logic [31:0] ADDR_TIMER     = 32'h0000_F004;
   localparam logic [31:0] ADDR_UART_TX   = 32'h0000_F008;
   localparam logic [31:0] ADDR_UART_STAT = 32'h0000_F00C;

   // Byte limit of the RAM region for the default 10-bit word address
   localparam int unsigned RAM_AW_DEFAULT    = 10;
   localparam logic [31:0] RAM_LIMIT_DEFAULT = 32'h0000_1000;

   localparam int unsigned STAT_BUSY = 0;
   localparam int unsigned STAT_OVR  = 1;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_e;

   // True when a byte address falls inside a RAM of 2^aw words
   function automatic logic is_ram_addr(input logic [31:0] addr, input int unsigned aw);
      return (addr >> (aw + 2)) == 32'd0;
   endfunction

endpackage

// File: rtl/bus_ctrl_if.sv
// bus_ctrl_if
// CPU data-bus port between top_cpu (master) and bus_ctrl (slave).
//   cpu_bc_addr : byte address from the CPU
//   cpu_bc_data : write data from the CPU
//   cpu_bc_rw   : 1 = write, 0 = read; every cycle is a transaction
//   bc_cpu_data : registered read data back to the CPU
interface bus_ctrl_if;

   logic [31:0] cpu_bc_addr;
   logic [31:0] cpu_bc_data;
   logic        cpu_bc_rw;
   logic [31:0] bc_cpu_data;

   modport master (
      output cpu_bc_addr,
      output cpu_bc_data,
      output cpu_bc_rw,
      input  bc_cpu_data
   );

   modport slave (
      input  cpu_bc_addr,
      input  cpu_bc_data,
      input  cpu_bc_rw,
      output bc_cpu_data
   );

endinterface

// File: rtl/bus_ctrl_uart_tx.sv
// uart_tx
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit,
// each held for CLKS_PER_BIT clock cycles.
//   clk, rst : clock and asynchronous active-low reset
//   start    : request to send data; taken only while ready is high
//   data     : byte to send
//   busy     : a frame is in progress (state is not IDLE)
//   ready    : a start this cycle will be accepted (idle, or the stop bit
//              is in its final cycle so a new frame follows back to back)
//   txd      : serial output, idles high
module uart_tx
   import bus_ctrl_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       ready,
   output logic       txd
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             txd_q, txd_d;
   logic             last_tick;

   assign last_tick = (bit_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
   assign busy      = (state_q != UART_IDLE);
   assign ready     = (state_q == UART_IDLE) || ((state_q == UART_STOP) && last_tick);
   assign txd       = txd_q;

   // State register; reset forces the line high and abandons any frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= UART_IDLE;
         bit_cnt_q <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         txd_q     <= txd_d;
      end
   end

   // Next-state logic. The bit counter free-runs over one bit period while
   // a frame is active; the line value for the next bit is loaded on the
   // last tick of the current one so txd changes exactly on the boundary.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = last_tick ? '0 : bit_cnt_q + 1'b1;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      txd_d     = txd_q;
      case (state_q)
         UART_IDLE: begin
            bit_cnt_d = '0;
            if (start) begin
               state_d = UART_START;
               shift_d = data;
               txd_d   = 1'b0;
            end
         end
         UART_START: begin
            if (last_tick) begin
               state_d   = UART_DATA;
               bit_idx_d = '0;
               txd_d     = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
            end
         end
         UART_DATA: begin
            if (last_tick) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = UART_STOP;
                  txd_d   = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
                  txd_d     = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end
         end
         UART_STOP: begin
            if (last_tick) begin
               if (start) begin
                  state_d = UART_START;
                  shift_d = data;
                  txd_d   = 1'b0;
               end else begin
                  state_d = UART_IDLE;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = UART_IDLE;
            txd_d   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/bus_ctrl.sv
// bus_ctrl
// Far end of the CPU data-bus port. Decodes each cycle's request to the
// word-addressed data RAM or to the LED latch, free-running timer and
// UART transmitter registers; read data is returned one cycle later.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : CPU request (address, write data, rw) and read data
//   led      : LED latch
//   uart_txd : UART serial output, idles high
module bus_ctrl
   import bus_ctrl_pkg::*;
#(
   parameter int unsigned RAM_AW       = RAM_AW_DEFAULT,
   parameter int unsigned LED_W        = 16,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic             clk,
   input  logic             rst,
   bus_ctrl_if.slave        bus,
   output logic [LED_W-1:0] led,
   output logic             uart_txd
);

   logic [31:0]       ram [2**RAM_AW];
   logic [31:0]       addr_word;
   logic [RAM_AW-1:0] word_idx;
   logic              sel_ram, sel_led, sel_timer, sel_tx, sel_stat;
   logic              wr, rd;
   logic [31:0]       timer_q, timer_inc;
   logic              overrun_q;
   logic              tx_busy, tx_ready, tx_start;
   logic [31:0]       rd_data;

   // Low address bits are masked rather than dropped so the whole bus is
   // decoded against word-aligned register addresses.
   assign addr_word = bus.cpu_bc_addr & ~32'h3;
   assign word_idx  = addr_word[RAM_AW+1:2];
   assign sel_ram   = is_ram_addr(addr_word, RAM_AW);
   assign sel_led   = (addr_word == ADDR_LED);
   assign sel_timer = (addr_word == ADDR_TIMER);
   assign sel_tx    = (addr_word == ADDR_UART_TX);
   assign sel_stat  = (addr_word == ADDR_UART_STAT);
   assign wr        = bus.cpu_bc_rw;
   assign rd        = !bus.cpu_bc_rw;
   assign timer_inc = timer_q + 32'd1;
   assign tx_start  = wr && sel_tx && tx_ready;

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_tx (
      .clk  (clk),
      .rst  (rst),
      .start(tx_start),
      .data (bus.cpu_bc_data[7:0]),
      .busy (tx_busy),
      .ready(tx_ready),
      .txd  (uart_txd)
   );

   // Data RAM write port; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (wr && sel_ram) begin
         ram[word_idx] <= bus.cpu_bc_data;
      end
   end

   // Timer read returns the count being written at this edge, so a value V
   // loaded at edge N reads back as V+k when sampled at edge N+k.
   always_comb begin
      rd_data = '0;
      if (sel_ram) begin
         rd_data = ram[word_idx];
      end else if (sel_led) begin
         rd_data = 32'(led);
      end else if (sel_timer) begin
         rd_data = timer_inc;
      end else if (sel_stat) begin
         rd_data[STAT_BUSY] = tx_busy;
         rd_data[STAT_OVR]  = overrun_q;
      end
   end

   // Peripheral registers and read-data register. A CPU load of the timer
   // takes priority over the increment; a newly detected overrun takes
   // priority over the clear-on-read of the status register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led             <= '0;
         timer_q         <= '0;
         overrun_q       <= 1'b0;
         bus.bc_cpu_data <= '0;
      end else begin
         if (wr && sel_led) begin
            led <= bus.cpu_bc_data[LED_W-1:0];
         end
         if (wr && sel_timer) begin
            timer_q <= bus.cpu_bc_data;
         end else begin
            timer_q <= timer_inc;
         end
         if (wr && sel_tx && !tx_ready) begin
            overrun_q <= 1'b1;
         end else if (rd && sel_stat) begin
            overrun_q <= 1'b0;
         end
         bus.bc_cpu_data <= wr ? 32'd0 : rd_data;
      end
   end

endmodule

// File: tb/tb_bus_ctrl.sv
// tb_bus_ctrl
// Self-checking bench for bus_ctrl with CLKS_PER_BIT=4. A reference model
// tracks RAM, LED, timer and UART frame timing in terms of edge numbers and
// checks read data, LED and serial line after every clock edge.
module tb_bus_ctrl;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk;
   logic        rst;
   logic [15:0] led;
   logic        uart_txd;

   bus_ctrl_if bus_if ();

   bus_ctrl #(
      .RAM_AW      (10),
      .LED_W       (16),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus_if.slave),
      .led     (led),
      .uart_txd(uart_txd)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          edge_cnt = 0;
   logic [31:0] ram_m [int];
   logic [15:0] led_m;
   logic [31:0] t_base;
   int          t_edge;
   int          tx_start_e;
   int          tx_end_e;
   logic [7:0]  tx_byte;
   logic        ovr_m;
   logic [31:0] exp_rd;

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      led_m      = '0;
      t_base     = '0;
      t_edge     = edge_cnt;
      tx_start_e = -100000;
      tx_end_e   = edge_cnt;
      tx_byte    = '0;
      ovr_m      = 1'b0;
   endtask

   function automatic logic exp_txd(input int e);
      int b;
      if (e >= tx_start_e && e < tx_end_e) begin
         b = (e - tx_start_e) / CPB;
         if (b == 0) return 1'b0;
         if (b <= 8) return tx_byte[b-1];
      end
      return 1'b1;
   endfunction

   // One bus transaction: drive at the falling edge, let the rising edge
   // sample it, update the model, then compare all outputs.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic rw);
      logic [31:0] aw;
      int          e;
      logic        busy_pre;
      @(negedge clk);
      bus_if.cpu_bc_addr = addr;
      bus_if.cpu_bc_data = data;
      bus_if.cpu_bc_rw   = rw;
      @(posedge clk);
      edge_cnt++;
      e        = edge_cnt;
      aw       = addr & ~32'h3;
      busy_pre = (tx_start_e <= e - 1) && (e - 1 < tx_end_e);
      exp_rd   = '0;
      if (rw) begin
         if (aw < 32'h1000) ram_m[int'(aw >> 2)] = data;
         else if (aw == 32'hF000) led_m = data[15:0];
         else if (aw == 32'hF004) begin
            t_base = data;
            t_edge = e;
         end else if (aw == 32'hF008) begin
            if (e >= tx_end_e) begin
               tx_start_e = e;
               tx_end_e   = e + FRAME;
               tx_byte    = data[7:0];
            end else begin
               ovr_m = 1'b1;
            end
         end
      end else begin
         if (aw < 32'h1000) exp_rd = ram_m[int'(aw >> 2)];
         else if (aw == 32'hF000) exp_rd = {16'h0, led_m};
         else if (aw == 32'hF004) exp_rd = t_base + 32'(e - t_edge);
         else if (aw == 32'hF00C) begin
            exp_rd = {30'h0, ovr_m, busy_pre};
            ovr_m  = 1'b0;
         end
      end
      #1;
      checkOutput("bc_cpu_data", bus_if.bc_cpu_data, exp_rd);
      checkOutput("led", {16'h0, led}, {16'h0, led_m});
      checkOutput("uart_txd", {31'h0, uart_txd}, {31'h0, exp_txd(e)});
   endtask

   initial begin
      logic [31:0] addr;
      logic [31:0] data;
      logic        rw;
      int          pick;

      rst                = 1'b0;
      bus_if.cpu_bc_addr = '0;
      bus_if.cpu_bc_data = '0;
      bus_if.cpu_bc_rw   = 1'b0;
      modelReset();

      // Power-on reset values
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset bc_cpu_data", bus_if.bc_cpu_data, 32'h0);
      checkOutput("reset led", {16'h0, led}, 32'h0);
      checkOutput("reset uart_txd", {31'h0, uart_txd}, 32'h1);
      #2 rst = 1'b1;
      modelReset();

      // Reset in the middle of a frame with LED and read data non-zero
      applyStimulus(32'h0000_F000, 32'h0000_1234, 1'b1);
      applyStimulus(32'h0000_F008, 32'h0000_00A3, 1'b1);
      applyStimulus(32'h0000_2000, 32'h0, 1'b0);
      applyStimulus(32'h0000_F000, 32'h0, 1'b0);
      #2 rst = 1'b0;
      #1;
      checkOutput("midframe reset uart_txd", {31'h0, uart_txd}, 32'h1);
      checkOutput("midframe reset led", {16'h0, led}, 32'h0);
      checkOutput("midframe reset bc_cpu_data", bus_if.bc_cpu_data, 32'h0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      modelReset();
      applyStimulus(32'h0000_F00C, 32'h0, 1'b0);

      // RAM round trip and an unmapped read
      applyStimulus(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
      applyStimulus(32'h0000_0010, 32'h0, 1'b0);
      applyStimulus(32'h0000_2000, 32'h0, 1'b0);

      // LED latch truncation and zero-extended read
      applyStimulus(32'h0000_F000, 32'h0001_A5A5, 1'b1);
      applyStimulus(32'h0000_F000, 32'h0, 1'b0);

      // Timer load, count and wrap
      applyStimulus(32'h0000_F004, 32'h0000_0100, 1'b1);
      repeat (4) applyStimulus(32'h0000_2000, 32'h0, 1'b0);
      applyStimulus(32'h0000_F004, 32'h0, 1'b0);
      applyStimulus(32'h0000_F004, 32'hFFFF_FFFF, 1'b1);
      applyStimulus(32'h0000_F004, 32'h0, 1'b0);

      // Frame of 0x55, overrun while busy, clear-on-read of overrun
      applyStimulus(32'h0000_F008, 32'h0000_0055, 1'b1);
      repeat (10) applyStimulus(32'h0000_0010, 32'h0, 1'b0);
      applyStimulus(32'h0000_F008, 32'h0000_003C, 1'b1);
      applyStimulus(32'h0000_F00C, 32'h0, 1'b0);
      applyStimulus(32'h0000_F00C, 32'h0, 1'b0);

      // Back-to-back frame written on the exact edge the first one ends
      while (edge_cnt + 1 < tx_end_e) applyStimulus(32'h0000_F00C, 32'h0, 1'b0);
      applyStimulus(32'h0000_F008, 32'h0000_0081, 1'b1);
      repeat (FRAME + 4) applyStimulus(32'h0000_F00C, 32'h0, 1'b0);

      // Randomized traffic over all regions, low address bits scrambled
      for (int i = 0; i < 600; i++) begin
         pick = int'($urandom_range(0, 11));
         rw   = 1'($urandom_range(0, 1));
         data = $urandom;
         case (pick)
            0, 1, 2: addr = 32'($urandom_range(0, 7)) << 2;
            3:       addr = 32'h0000_0FFC;
            4:       addr = 32'h0000_F000;
            5:       addr = 32'h0000_F004;
            6:       begin
               addr = 32'h0000_F008;
               if ($urandom_range(0, 3) != 0) rw = 1'b0;
            end
            7, 8:    addr = 32'h0000_F00C;
            9:       addr = 32'h0000_1000;
            10:      addr = 32'h0000_F010;
            default: addr = 32'h8000_F000;
         endcase
         addr = addr | 32'($urandom_range(0, 3));
         if (!rw && (addr & ~32'h3) < 32'h1000 && !ram_m.exists(int'(addr >> 2))) rw = 1'b1;
         applyStimulus(addr, data, rw);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

Bus controller at the far end of the CPU data-bus port. Each cycle it accepts one request from `top_cpu`: write data, address and read/write strobe. It decodes the address to a word-addressed data RAM or to one of four memory-mapped peripheral registers (LED latch, timer, UART transmit data, UART status). Read data returns to the CPU one cycle later on `bc_cpu_data`. It contains the only sequential peripheral logic on the data side of the design.

## Interface
Parameters:
- `RAM_AW`, 10: data RAM word-address width (1024 words, byte range 0x0000_0000–0x0000_0FFF).
- `LED_W`, 16: LED latch width.
- `CLKS_PER_BIT`, 434: UART bit period in `clk` cycles (minimum 2).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous reset, active-low.
- `cpu_bc_addr` input 32: byte address; bits [1:0] are ignored.
- `cpu_bc_data` input 32: write data.
- `cpu_bc_rw` input 1: 1 = write, 0 = read. Every cycle is a transaction; there is no valid strobe.
- `bc_cpu_data` output 32: registered read data.
- `led` output LED_W: LED latch.
- `uart_txd` output 1: serial out, 8N1, idles high.

## Operation
Address map (word-aligned):
- 0x0000_0000 + 4·i, i < 2^RAM_AW: RAM word i. Reads and writes.
- 0x0000_F000 LED: a write loads `cpu_bc_data[LED_W-1:0]`. A read returns the value zero-extended.
- 0x0000_F004 TIMER: a 32-bit free-running up counter, +1 every cycle, wraps from 0xFFFF_FFFF to 0. A write loads `cpu_bc_data`. A read returns the count at the sampling edge.
- 0x0000_F008 UART_TX:
  - Write with busy=0: starts a frame with `cpu_bc_data[7:0]`.
  - Write with busy=1: the data is dropped and `overrun` is set.
  - Read: returns 0.
- 0x0000_F00C UART_STAT: a read returns {30'b0, overrun, busy} and clears `overrun`. Writes are ignored.
- Any other address: a read returns 0 and a write has no effect.

Simultaneous events:
- If an overrun is set and a status read clears it on the same edge, set wins.
- If the timer is written on a cycle, the load wins over the increment.

UART frame:
- Start bit (0), then 8 data bits LSB first, then stop bit (1).
- Each bit lasts `CLKS_PER_BIT` cycles, so a full frame is 10·CLKS_PER_BIT cycles.

UART state machine:
- States: IDLE, START, DATA, STOP.
- IDLE→START on an accepted TX write.
- START→DATA after one bit period.
- DATA→STOP after 8 bit periods.
- STOP→IDLE after one bit period.
- busy = (state ≠ IDLE).

## Timing
- Request sampled at rising edge N; `bc_cpu_data` is valid after edge N and held until edge N+1 (1-cycle read latency).
- On a write cycle, `bc_cpu_data` becomes 0 after the edge.
- RAM write at edge N: a read of the same word at edge N+1 returns the new value.
- UART:
  - An accepted TX write sampled at edge N drives `uart_txd` low and busy=1 from edge N.
  - `uart_txd` returns high, and busy=0, at edge N+10·CLKS_PER_BIT.
  - A TX write sampled exactly at that edge is accepted.
- Timer: a write of V at edge N gives TIMER=V after edge N. A read sampled at edge N+k returns V+k.
- Reset (`rst`=0), asynchronous and effective immediately, including mid-frame:
  - Outputs: `bc_cpu_data`=0, `led`=0, `uart_txd`=1.
  - Internal state: timer=0, busy=0, overrun=0, UART state IDLE.
  - RAM contents are not reset.

## Structure
- Shared package `bus_ctrl_pkg`:
  - Address constants ADDR_LED, ADDR_TIMER, ADDR_UART_TX, ADDR_UART_STAT.
  - RAM region limit.
  - Status bit indices STAT_BUSY=0, STAT_OVR=1.
  - UART state encoding.
- Sub-module `uart_tx` contains:
  - Bit-period counter and bit index.
  - Shift register and the 4-state machine.
  - Interface: `clk`, `rst`, `start`, `data[7:0]`, `busy`, `txd`.
- The top level holds address decode, RAM array, LED latch, timer, overrun flag and the read-data register.

## Test plan
- Reset with `rst`=0 mid-frame → `uart_txd`=1 at once, `led`=0, `bc_cpu_data`=0. Status read after release → 0x0.
- Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 → `bc_cpu_data`=0xDEADBEEF one cycle after the read. A read of 0x0000_2000 (unmapped) → 0.
- Write 0x0001_A5A5 to LED → `led`=0xA5A5 (LED_W=16). LED read → 0x0000_A5A5.
- Write 0x0000_0100 to TIMER, then read 5 cycles later → 0x0000_0105. Write 0xFFFF_FFFF, read 1 cycle later → 0x0000_0000.
- With CLKS_PER_BIT=4, write 0x55 to UART_TX → `uart_txd` gives 0 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, then 1. Busy=1 for exactly 40 cycles.
- Second TX write while busy → data not sent and status reads 0x3. The next status read → 0x1 (overrun cleared, busy still set).
